mdu: RTL and testbench

Multiply/divide unit that produces the HI/LO writeback stream for the CPU's HI/LO register pair. It sits in the EX stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the decoder. It runs multi-cycle arithmetic, holding `busy` so the pipeline stalls. It then presents results as `we_hi`/`we_lo`/`wb_hi`/`wb_lo` for one cycle to the HI/LO register file.

---
 rtl/mdu.sv | 183 ++++++++++++++++++
 tb/tb_mdu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multiply/divide unit feeding the HI/LO register pair.
// MULT/MULTU use a 32-iteration shift-add multiplier.
// DIV/DIVU use a 32-iteration restoring divider.
// MTHI/MTLO pass src1 straight through in a single cycle.
// Optional macro MDU_FAST_MUL_EN replaces the iterative multiplier with a
// single-cycle combinational 32x32 multiply. Division is unchanged.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        we_hi,
    output logic        we_lo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] wb_hi_q, wb_hi_d;
    logic [31:0] wb_lo_q, wb_lo_d;

    // Magnitude of an operand; unsigned ops pass the value through.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Operand magnitudes at issue time (even op codes are the signed ones).
    logic        in_signed;
    logic [31:0] in_mag1, in_mag2;
    assign in_signed = ~op[0];
    assign in_mag1   = mag(src1, in_signed);
    assign in_mag2   = mag(src2, in_signed);

    // Operand magnitudes of the latched operation.
    logic        q_signed;
    logic [31:0] q_mag1, q_mag2;
    assign q_signed = ~op_q[0];
    assign q_mag1   = mag(src1_q, q_signed);
    assign q_mag2   = mag(src2_q, q_signed);

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, q_mag1} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Restoring step: acc = {partial remainder, dividend bits / quotient bits}.
    // The shifted remainder can need 33 bits, but the difference always fits in 32.
    logic [32:0] div_r;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    assign div_r    = {acc_q[63:32], acc_q[31]};
    assign div_ge   = div_r >= {1'b0, q_mag2};
    assign div_diff = div_r[31:0] - q_mag2;
    assign div_next = {(div_ge ? div_diff : div_r[31:0]), acc_q[30:0], div_ge};

    logic [63:0] step_next;
    assign step_next = op_q[1] ? div_next : mul_next;

    // Sign fix-up of the final iteration's result.
    logic        neg_res;
    logic [63:0] mul_res;
    logic [31:0] fin_hi, fin_lo;
    assign neg_res = q_signed & (src1_q[31] ^ src2_q[31]);
    assign mul_res = neg_res ? (~step_next + 64'd1) : step_next;
    always_comb begin
        if (!op_q[1]) begin
            fin_hi = mul_res[63:32];
            fin_lo = mul_res[31:0];
        end else if (src2_q == 32'd0) begin
            fin_hi = src1_q;
            fin_lo = 32'hFFFF_FFFF;
        end else begin
            fin_lo = neg_res ? (~step_next[31:0] + 32'd1) : step_next[31:0];
            fin_hi = (q_signed && src1_q[31]) ? (~step_next[63:32] + 32'd1) : step_next[63:32];
        end
    end

`ifdef MDU_FAST_MUL_EN
    // Single-cycle product; the low 64 bits of the extended operands give
    // both the signed and the unsigned result.
    logic [63:0] fast_ext1, fast_ext2, fast_prod;
    assign fast_ext1 = {(in_signed ? {32{src1[31]}} : 32'd0), src1};
    assign fast_ext2 = {(in_signed ? {32{src2[31]}} : 32'd0), src2};
    assign fast_prod = fast_ext1 * fast_ext2;
`endif

    // Next-state and datapath update; flush overrides everything.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        acc_d   = acc_q;
        wb_hi_d = wb_hi_q;
        wb_lo_d = wb_lo_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (state_q == S_CALC) begin
            acc_d = step_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
                state_d = S_DONE;
                wb_hi_d = fin_hi;
                wb_lo_d = fin_lo;
            end
        end else begin
            state_d = S_IDLE;
            if (start && !op[2]) begin
                op_d    = op;
                src1_d  = src1;
                src2_d  = src2;
                cnt_d   = 6'd0;
                acc_d   = {32'd0, (op[1] ? in_mag1 : in_mag2)};
                state_d = S_CALC;
`ifdef MDU_FAST_MUL_EN
                if (!op[1]) begin
                    state_d = S_DONE;
                    wb_hi_d = fast_prod[63:32];
                    wb_lo_d = fast_prod[31:0];
                end
`endif
            end else if (start && op == OP_MTHI) begin
                op_d    = op;
                wb_hi_d = src1;
                state_d = S_DONE;
            end else if (start && op == OP_MTLO) begin
                op_d    = op;
                wb_lo_d = src1;
                state_d = S_DONE;
            end
        end
    end

    // State and datapath registers; reset clears everything, including results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 3'd0;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            acc_q   <= 64'd0;
            wb_hi_q <= 32'd0;
            wb_lo_q <= 32'd0;
        end else begin
            // NOTE: non-blocking updates so all flops sample pre-edge values together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            acc_q   <= acc_d;
            wb_hi_q <= wb_hi_d;
            wb_lo_q <= wb_lo_d;
        end
    end

    // Status and write enables decode from the registered state; flush gates the write.
    assign busy  = (state_q == S_CALC);
    assign we_hi = (state_q == S_DONE) && (op_q != OP_MTLO) && !flush;
    assign we_lo = (state_q == S_DONE) && (op_q != OP_MTHI) && !flush;
    assign wb_hi = wb_hi_q;
    assign wb_lo = wb_lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected writes, monitor pops on each write.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        flush = 1'b0;
    logic        busy, we_hi, we_lo;
    logic [31:0] wb_hi, wb_lo;

    mdu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src1(src1), .src2(src2),
        .flush(flush), .busy(busy), .we_hi(we_hi), .we_lo(we_lo), .wb_hi(wb_hi), .wb_lo(wb_lo)
    );

    always #5 clk = ~clk;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    typedef struct {
        logic        hie;
        logic        loe;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   wr_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and compares every write against the scoreboard.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (we_hi || we_lo) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_write", {62'd0, we_hi, we_lo}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_we"}, {62'd0, we_hi, we_lo}, {62'd0, e.hie, e.loe});
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                if (e.hie) check({e.name, "_hi"}, {32'd0, wb_hi}, {32'd0, e.hi});
                if (e.loe) check({e.name, "_lo"}, {32'd0, wb_lo}, {32'd0, e.lo});
            end
        end
    end

    // Push an expectation; call just before issue() so cyc is the pre-edge count.
    task automatic expect_wr(input logic hie, input logic loe, input logic [31:0] hi,
                             input logic [31:0] lo, input int lat, input string name);
        exp_t e;
        e.hie = hie; e.loe = loe; e.hi = hi; e.lo = lo;
        e.cyc = cyc + 1 + lat; e.name = name;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check({name, "_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
        #1;
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input int lat, input string name);
        busy_cnt = 0;
        expect_wr(1'b1, 1'b1, hi, lo, lat, name);
        issue(o, a, b);
        wait_drain(name);
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;
        #12;
        check("reset_outputs", {27'd0, busy, we_hi, we_lo, wb_hi}, 64'd0);
        check("reset_wb_lo", {32'd0, wb_lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run(3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, "mult_m3x5");
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, "multu_max");
        run(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, "mult_7xm3");
        run(3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_LAT, "multu_2p32");
        run(3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, "div_m7d2");
        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT, "div_minneg");
        run(3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT, "div_7dm2");
        run(3'd3, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, DIV_LAT, "divu_100d7");
        run(3'd3, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, DIV_LAT, "divu_by0");
        run(3'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT, "div_by0");

        // MTHI, then MTLO in its DONE cycle, then DIVU in that DONE cycle (no bubble).
        busy_cnt = 0;
        expect_wr(1'b1, 1'b0, 32'h1234_5678, 32'd0, 0, "mthi");
        issue(3'd4, 32'h1234_5678, 32'd0);
        expect_wr(1'b0, 1'b1, 32'd0, 32'hCAFE_F00D, 0, "mtlo_b2b");
        issue(3'd5, 32'hCAFE_F00D, 32'd0);
        expect_wr(1'b1, 1'b1, 32'd0, 32'd3, DIV_LAT, "divu_b2b");
        issue(3'd3, 32'd9, 32'd3);
        wait_drain("b2b");
        check("b2b_busy_cycles", 64'(busy_cnt), 64'(DIV_LAT));

        // Flush on the 10th busy cycle: back to IDLE, no write ever.
        wr0 = wr_cnt;
        issue(3'd3, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_idle_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_no_write", 64'(wr_cnt - wr0), 64'd0);

        // Flush together with start: start dropped. Reserved op: ignored.
        wr0 = wr_cnt;
        flush = 1'b1;
        issue(3'd3, 32'd50, 32'd5);
        flush = 1'b0;
        check("flush_start_busy", {63'd0, busy}, 64'd0);
        issue(3'd6, 32'd1, 32'd1);
        check("reserved_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_start_reserved_no_write", 64'(wr_cnt - wr0), 64'd0);

        // Reset mid-CALC: outputs clear at once, no write afterwards.
        wr0 = wr_cnt;
        issue(3'd3, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {27'd0, busy, we_hi, we_lo, wb_hi}, 64'd0);
        check("rst_mid_wb_lo", {32'd0, wb_lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_mid_no_write", 64'(wr_cnt - wr0), 64'd0);

        // Sanity after reset: unit still works.
        @(posedge clk); #1;
        run(3'd2, 32'd21, 32'd4, 32'd1, 32'd5, DIV_LAT, "div_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
